// File: rtl/cgra_pkg.sv
// rtl/cgra_pkg.sv - shared encodings and command layout for the tile array sequencer
package cgra_pkg;

    // Two-bit switch state carried in the top bits of every switch byte
    localparam logic [1:0] STATE_WEIGHT  = 2'b00;
    localparam logic [1:0] STATE_CFG     = 2'b01;
    localparam logic [1:0] STATE_OPERAND = 2'b10;
    localparam logic [1:0] STATE_END     = 2'b11;

    // END state with a zero payload leaves the tile configuration untouched
    localparam logic [7:0] IDLE_BYTE_DEFAULT = {STATE_END, 6'h00};

    // Command kinds; any kind with bit 1 set is reserved and rejected
    localparam logic [1:0] KIND_WRITE = 2'b00;
    localparam logic [1:0] KIND_READ  = 2'b01;

    // Command word field offsets
    localparam int CMD_WIDTH = 16;
    localparam int KIND_LSB  = 14;
    localparam int TILE_LSB  = 8;
    localparam int TILE_W    = 6;
    localparam int BYTE_LSB  = 0;

    typedef enum logic [2:0] {
        SEQ_IDLE,
        SEQ_ISSUE,
        SEQ_WAIT,
        SEQ_CAPTURE,
        SEQ_RESP
    } seq_state_t;

    typedef struct packed {
        logic [1:0] kind;
        logic [5:0] tile;
        logic [7:0] data;
    } cmd_t;

    function automatic cmd_t unpack_cmd(input logic [CMD_WIDTH-1:0] word);
        cmd_t c;
        c.kind = word[KIND_LSB +: 2];
        c.tile = word[TILE_LSB +: TILE_W];
        c.data = word[BYTE_LSB +: 8];
        return c;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// rtl/cmd_fifo.sv - synchronous command FIFO with registered ready and occupancy count
module cmd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_valid,
    output logic             push_ready,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [AW:0]      count_next;

    assign do_push = push_valid & push_ready;
    assign do_pop  = pop & (count != '0);
    assign head    = mem[rd_ptr];

    // Occupancy after this cycle's push/pop; ready is derived from it so it is a clean register
    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - (AW+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_ready <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count      <= count_next;
            push_ready <= (count_next != (AW+1)'(DEPTH));
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/tile_cmd_sequencer.sv
// rtl/tile_cmd_sequencer.sv - drives command bytes into compute tiles and captures read results
module tile_cmd_sequencer
    import cgra_pkg::*;
#(
    parameter int         NUM_TILES  = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter int         RD_LATENCY = 2,
    parameter logic [7:0] IDLE_BYTE  = IDLE_BYTE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [15:0]            cmd_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [7:0]             rsp_data,
    output logic [5:0]             rsp_tile,
    output logic [NUM_TILES*8-1:0] tile_sw_in,
    input  logic [NUM_TILES*8-1:0] tile_sw_out,
    output logic                   busy,
    output logic                   err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t             state;
    logic [CMD_WIDTH-1:0]   fifo_head;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_pop;
    cmd_t                   head_cmd;
    logic                   head_bad;
    logic [5:0]             cur_tile;
    logic [3:0]             lat_cnt;
    logic [NUM_TILES*8-1:0] issue_bus;
    logic [7:0]             sel_out;

    cmd_fifo #(
        .WIDTH (CMD_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_valid (cmd_valid),
        .push_ready (cmd_ready),
        .push_data  (cmd_data),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .count      (fifo_count)
    );

    assign fifo_pop = (state == SEQ_ISSUE);
    assign head_cmd = unpack_cmd(fifo_head);
    assign head_bad = head_cmd.kind[1] | ({1'b0, head_cmd.tile} >= 7'(NUM_TILES));
    assign busy     = (state != SEQ_IDLE) | (fifo_count != '0);

    // Fan-out: the head command's byte on its tile, idle byte everywhere else
    always_comb begin
        issue_bus = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            issue_bus[i*8 +: 8] = (head_cmd.tile == 6'(i)) ? head_cmd.data : IDLE_BYTE;
        end
    end

    // Fan-in: pick the switch output of the tile being read
    always_comb begin
        sel_out = '0;
        for (int i = 0; i < NUM_TILES; i++) begin
            if (cur_tile == 6'(i)) begin
                sel_out = tile_sw_out[i*8 +: 8];
            end
        end
    end

    // Sequencer FSM; every tile byte and response field is a register, so the
    // issued byte shows up one cycle after ISSUE and is replaced by idle the cycle after
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEQ_IDLE;
            tile_sw_in <= {NUM_TILES{IDLE_BYTE}};
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tile   <= '0;
            err        <= 1'b0;
            cur_tile   <= '0;
            lat_cnt    <= '0;
        end else begin
            tile_sw_in <= {NUM_TILES{IDLE_BYTE}};
            case (state)
                SEQ_IDLE: begin
                    if ((fifo_count != '0) && !rsp_valid) begin
                        state <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    cur_tile <= head_cmd.tile;
                    if (head_bad) begin
                        err   <= 1'b1;
                        state <= SEQ_IDLE;
                    end else begin
                        tile_sw_in <= issue_bus;
                        if (head_cmd.kind == KIND_READ) begin
                            lat_cnt <= 4'(RD_LATENCY);
                            state   <= SEQ_WAIT;
                        end else begin
                            state <= SEQ_IDLE;
                        end
                    end
                end
                SEQ_WAIT: begin
                    if (lat_cnt <= 4'd1) begin
                        state <= SEQ_CAPTURE;
                    end else begin
                        lat_cnt <= lat_cnt - 4'd1;
                    end
                end
                SEQ_CAPTURE: begin
                    rsp_data  <= sel_out;
                    rsp_tile  <= cur_tile;
                    rsp_valid <= 1'b1;
                    state     <= SEQ_RESP;
                end
                SEQ_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= SEQ_IDLE;
                    end
                end
                default: begin
                    state <= SEQ_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_cmd_sequencer.sv
// tb/tb_tile_cmd_sequencer.sv - scoreboard bench for tile_cmd_sequencer
module tb_tile_cmd_sequencer;

    localparam int NT = 4;
    localparam int RL = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_data;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [7:0]      rsp_data;
    logic [5:0]      rsp_tile;
    logic [NT*8-1:0] tile_sw_in;
    logic [NT*8-1:0] tile_sw_out;
    logic            busy;
    logic            err;

    logic [7:0]  tile_out [NT];
    logic [13:0] drv_q [$];
    logic [13:0] rsp_q [$];
    int          checks = 0;
    int          errors = 0;
    bit          exp_err = 1'b0;
    bit          saw_full = 1'b0;
    bit          rand_rdy = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NT; i++) tile_sw_out[i*8 +: 8] = tile_out[i];
    end

    tile_cmd_sequencer #(
        .NUM_TILES  (NT),
        .FIFO_DEPTH (4),
        .RD_LATENCY (RL),
        .IDLE_BYTE  (8'hC0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_data    (cmd_data),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_tile    (rsp_tile),
        .tile_sw_in  (tile_sw_in),
        .tile_sw_out (tile_sw_out),
        .busy        (busy),
        .err         (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: what a command must cause, decided only from its fields
    task automatic model_push(input logic [15:0] c);
        int ti;
        ti = int'(c[13:8]);
        if (c[15] || ti >= NT) begin
            exp_err = 1'b1;
        end else begin
            drv_q.push_back({c[13:8], c[7:0]});
            if (c[15:14] == 2'b01) rsp_q.push_back({c[13:8], tile_out[ti]});
        end
    endtask

    // Called at a falling edge; returns at a falling edge after the command is taken
    task automatic push_cmd(input logic [15:0] c);
        int t;
        t = 0;
        cmd_data  = c;
        cmd_valid = 1'b1;
        while (!cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            chk("push_timeout", 32'(t), 32'd0);
        end else begin
            model_push(c);
            @(posedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((drv_q.size() != 0 || rsp_q.size() != 0 || busy) && t < 800) begin
            @(negedge clk);
            t++;
        end
        if (t >= 800) chk("drain_timeout", 32'(t), 32'd0);
        repeat (3) @(negedge clk);
        chk("err_flag", 32'(err), 32'(exp_err));
    endtask

    function automatic logic [15:0] rand_cmd(input bit allow_bad, input bit force_read,
                                             input bit force_write);
        logic [1:0] k;
        logic [5:0] tl;
        logic [7:0] b;
        k  = force_read ? 2'b01 : force_write ? 2'b00 : 2'($urandom_range(0, 1));
        tl = 6'($urandom_range(0, NT - 1));
        b  = 8'($urandom);
        if (b == 8'hC0) b = 8'h3C;
        if (allow_bad && $urandom_range(0, 9) == 0) begin
            if ($urandom_range(0, 1) == 1) k = 2'b10 | 2'($urandom_range(0, 1));
            else tl = 6'($urandom_range(NT, 63));
        end
        return {k, tl, b};
    endfunction

    always @(negedge clk) if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));

    // Monitor: compare tile drives and accepted responses against the scoreboard
    always begin : monitor
        int          n;
        int          ti;
        logic [7:0]  b;
        logic [13:0] e;
        bit          prev_hold;
        logic [7:0]  prev_data;
        logic [5:0]  prev_tile;
        @(negedge clk);
        #3;
        if (!rst) begin
            n  = 0;
            ti = 0;
            b  = 8'h00;
            for (int i = 0; i < NT; i++) begin
                if (tile_sw_in[i*8 +: 8] != 8'hC0) begin
                    n++;
                    ti = i;
                    b  = tile_sw_in[i*8 +: 8];
                end
            end
            if (n > 1) chk("multi_drive", 32'(n), 32'd1);
            if (n == 1) begin
                if (drv_q.size() == 0) begin
                    chk("unexpected_drive", {18'd0, 6'(ti), b}, 32'hFFFF);
                end else begin
                    e = drv_q.pop_front();
                    chk("drive", {18'd0, 6'(ti), b}, {18'd0, e});
                end
            end
            if (!cmd_ready) saw_full = 1'b1;
            if (prev_hold) begin
                chk("rsp_hold", {17'd0, rsp_valid, rsp_tile, rsp_data},
                    {17'd0, 1'b1, prev_tile, prev_data});
            end
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", {18'd0, rsp_tile, rsp_data}, 32'hFFFF);
                end else begin
                    e = rsp_q.pop_front();
                    chk("rsp", {18'd0, rsp_tile, rsp_data}, {18'd0, e});
                end
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
            prev_tile = rsp_tile;
        end else begin
            prev_hold = 1'b0;
        end
    end

    initial begin : stim
        int n;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 16'h0000;
        rsp_ready = 1'b1;
        tile_out[0] = 8'h11;
        tile_out[1] = 8'h5E;
        tile_out[2] = 8'h2A;
        tile_out[3] = 8'h97;
        repeat (3) @(negedge clk);
        chk("rst_tile_sw_in", tile_sw_in, {NT{8'hC0}});
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(rsp_data), 32'd0);
        chk("rst_rsp_tile", 32'(rsp_tile), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // single write
        push_cmd(16'h0103);
        drain();

        // single read with held response
        rsp_ready = 1'b0;
        push_cmd(16'h4282);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("read_latency", 32'(n), 32'(RL + 3));
        repeat (5) @(negedge clk);
        rsp_ready = 1'b1;
        drain();

        // fill the FIFO behind a stalled response
        rsp_ready = 1'b0;
        saw_full  = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) push_cmd(rand_cmd(1'b0, 1'b1, 1'b0));
            end
            begin
                repeat (30) @(negedge clk);
                rsp_ready = 1'b1;
            end
        join
        chk("fifo_filled", 32'(saw_full), 32'd1);
        drain();

        // bad commands dropped, following command still runs
        push_cmd(16'h0705);
        push_cmd(16'h8001);
        push_cmd(16'h0210);
        drain();

        // pointer wrap with writes only
        for (int i = 0; i < 12; i++) push_cmd(rand_cmd(1'b0, 1'b0, 1'b1));
        drain();

        // random mix with a randomly stalling consumer
        tile_out[0] = 8'($urandom);
        tile_out[3] = 8'($urandom);
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) push_cmd(rand_cmd(1'b1, 1'b0, 1'b0));
        drain();
        rand_rdy  = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);

        // reset in the middle of a read wait aborts it
        push_cmd(16'h4111);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_tile_sw_in", tile_sw_in, {NT{8'hC0}});
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);
        drv_q.delete();
        rsp_q.delete();
        exp_err = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (RL + 6) @(negedge clk);
        chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
        push_cmd(16'h0377);
        drain();

        chk("drv_q_empty", 32'(drv_q.size()), 32'd0);
        chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
